// File: rtl/keypad_pkg.sv
// Shared constants, FSM encoding and key map for the keypad entry controller.
package keypad_pkg;

  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam logic [3:0] KEY_CLEAR = 4'hA;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // True when exactly one active-low row line is pulled down.
  function automatic logic one_cold(input logic [3:0] r);
    return (r == 4'b0111) || (r == 4'b1011) || (r == 4'b1101) || (r == 4'b1110);
  endfunction

  // Column index and raw row sample to key code; row index 0 is row[3].
  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [3:0] r);
    logic [1:0] ri;
    logic [3:0] code;
    case (r)
      4'b0111: ri = 2'd0;
      4'b1011: ri = 2'd1;
      4'b1101: ri = 2'd2;
      default: ri = 2'd3;
    endcase
    case ({c, ri})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h4;
      4'b00_10: code = 4'h7;
      4'b00_11: code = 4'h0;
      4'b01_00: code = 4'h2;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h8;
      4'b01_11: code = 4'hE;
      4'b10_00: code = 4'h3;
      4'b10_01: code = 4'h6;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hF;
      4'b11_00: code = 4'hA;
      4'b11_01: code = 4'hB;
      4'b11_10: code = 4'hC;
      default:  code = 4'hD;
    endcase
    if (!one_cold(r)) begin
      code = KEY_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan-level debouncer: turns per-scan key results into one strobe per press.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       scan_done,
  input  logic [3:0] scan_code,
  output logic       strobe,
  output logic [3:0] code
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] RUN_LIMIT = CW'(DEBOUNCE_SCANS);

  logic          pressed_reg;
  logic [3:0]    cand_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] run_len;

  // Run length of the current scan result while released; counts restart on a new key.
  always_comb begin
    cnt_inc = cnt_reg + 1'b1;
    run_len = (scan_code == cand_reg) ? cnt_inc : CW'(1);
  end

  // Press/release acceptance; a different key while pressed only breaks the release run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pressed_reg <= 1'b0;
      cand_reg    <= KEY_NONE;
      cnt_reg     <= '0;
      strobe      <= 1'b0;
      code        <= KEY_NONE;
    end else begin
      strobe <= 1'b0;
      if (clear) begin
        pressed_reg <= 1'b0;
        cand_reg    <= KEY_NONE;
        cnt_reg     <= '0;
      end else if (scan_done) begin
        if (!pressed_reg) begin
          if (scan_code == KEY_NONE) begin
            cand_reg <= KEY_NONE;
            cnt_reg  <= '0;
          end else if (run_len == RUN_LIMIT) begin
            pressed_reg <= 1'b1;
            cand_reg    <= KEY_NONE;
            cnt_reg     <= '0;
            strobe      <= 1'b1;
            code        <= scan_code;
          end else begin
            cand_reg <= scan_code;
            cnt_reg  <= run_len;
          end
        end else begin
          if (scan_code != KEY_NONE) begin
            cnt_reg <= '0;
          end else if (cnt_inc == RUN_LIMIT) begin
            pressed_reg <= 1'b0;
            cnt_reg     <= '0;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
      end
    end
  end

endmodule

// File: rtl/keypad_entry_controller.sv
// Keypad column scanner, digit entry buffer and start/done handshake FSM.
module keypad_entry_controller
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int NUM_DIGITS     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              row,
  output logic [3:0]              col,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    key_strobe,
  output logic [3:0]              key_code,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    digits_valid
);

  localparam int TW = $clog2(SETTLE_CYCLES);
  localparam int NW = $clog2(NUM_DIGITS + 1);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SETTLE_CYCLES - 1);

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg;
  logic [1:0]      col_idx_reg;
  logic            found_reg;
  logic [3:0]      scan_code_reg;
  logic [NW-1:0]   count_reg;

  logic            scan_active;
  logic            sample_now;
  logic            acc_found;
  logic [3:0]      acc_code;
  logic            scan_done;
  logic            row_hit;

  // Scanner runs only while collecting; a start restarts it from column 0.
  always_comb begin
    scan_active = (state_reg == COLLECT) && !start;
    sample_now  = scan_active && (timer_reg == TIMER_LAST);
    row_hit     = one_cold(row);
    if ((col_idx_reg != 2'd0) && found_reg) begin
      acc_found = 1'b1;
      acc_code  = scan_code_reg;
    end else begin
      acc_found = row_hit;
      acc_code  = row_hit ? key_map(col_idx_reg, row) : KEY_NONE;
    end
    scan_done = sample_now && (col_idx_reg == 2'd3);
  end

  // Column timer and per-scan accumulator of the lowest one-cold column.
  always_ff @(posedge clk) begin
    if (!rst_n || !scan_active) begin
      timer_reg     <= '0;
      col_idx_reg   <= 2'd0;
      found_reg     <= 1'b0;
      scan_code_reg <= KEY_NONE;
    end else if (timer_reg == TIMER_LAST) begin
      timer_reg     <= '0;
      col_idx_reg   <= col_idx_reg + 2'd1;
      found_reg     <= acc_found;
      scan_code_reg <= acc_code;
    end else begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_reg != COLLECT),
    .scan_done(scan_done),
    .scan_code(acc_code),
    .strobe   (key_strobe),
    .code     (key_code)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: abort wins over start; DONE one cycle after the last digit lands.
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else if (start) begin
      state_next = COLLECT;
    end else if ((state_reg == COLLECT) && (count_reg == NW'(NUM_DIGITS))) begin
      state_next = DONE;
    end
  end

  // FSM outputs: columns idle high outside COLLECT.
  always_comb begin
    busy         = (state_reg == COLLECT);
    digits_valid = (state_reg == DONE);
    col          = busy ? ~(4'b0001 << col_idx_reg) : 4'hF;
  end

  // Entry buffer: strobes coinciding with start/abort are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits    <= '1;
      count_reg <= '0;
    end else if (abort) begin
      digits    <= digits;
      count_reg <= count_reg;
    end else if (start) begin
      digits    <= '1;
      count_reg <= '0;
    end else if ((state_reg == COLLECT) && key_strobe && (count_reg < NW'(NUM_DIGITS))) begin
      if (key_code <= 4'd9) begin
        digits    <= {digits[DW-5:0], key_code};
        count_reg <= count_reg + 1'b1;
      end else if (key_code == KEY_CLEAR) begin
        digits    <= '1;
        count_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Directed bench: keypad model driven from a per-column row pattern, strobe scoreboard.
module tb_keypad_entry_controller;

  localparam int SC = 4;
  localparam int DB = 2;
  localparam int ND = 4;
  localparam int SCAN = 4 * SC;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      row;
  logic [3:0]      col;
  logic            start;
  logic            abort;
  logic            busy;
  logic            key_strobe;
  logic [3:0]      key_code;
  logic [4*ND-1:0] digits;
  logic            digits_valid;

  logic [3:0] pat [4];
  logic [3:0] exp_q [$];
  logic [3:0] obs_q [$];
  int         rd_idx = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  keypad_entry_controller #(
    .SETTLE_CYCLES (SC),
    .DEBOUNCE_SCANS(DB),
    .NUM_DIGITS    (ND)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .key_strobe  (key_strobe),
    .key_code    (key_code),
    .digits      (digits),
    .digits_valid(digits_valid)
  );

  // Passive keypad: each driven-low column pulls down its pressed rows.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) row = row & pat[c];
    end
  end

  // Strobe monitor: record every accepted key seen on the outputs.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && key_strobe === 1'b1) obs_q.push_back(key_code);
  end

  function automatic logic [3:0] key_at(input int c, input int r);
    logic [3:0] k;
    case (c * 4 + r)
      0: k = 4'h1;  1: k = 4'h4;  2: k = 4'h7;  3: k = 4'h0;
      4: k = 4'h2;  5: k = 4'h5;  6: k = 4'h8;  7: k = 4'hE;
      8: k = 4'h3;  9: k = 4'h6; 10: k = 4'h9; 11: k = 4'hF;
      12: k = 4'hA; 13: k = 4'hB; 14: k = 4'hC; default: k = 4'hD;
    endcase
    return k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (key_at(c, r) == code) pat[c] = pat[c] & ~(4'b1000 >> r);
      end
    end
  endtask

  task automatic release_all();
    for (int c = 0; c < 4; c++) pat[c] = 4'hF;
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN) @(posedge clk);
    #1;
  endtask

  // Press for 3 scans, release for 3 scans; expected strobe queued with the stimulus.
  task automatic tap(input logic [3:0] code);
    exp_q.push_back(code);
    press(code);
    wait_scans(3);
    release_all();
    wait_scans(3);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Pop every expected strobe against the observed ones, then demand no extras.
  task automatic drain(input string tag);
    logic [3:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) begin
        chk({tag, "_code"}, 32'(obs_q[rd_idx]), 32'(e));
        rd_idx++;
      end else begin
        chk({tag, "_missing"}, 32'(obs_q.size()), 32'(rd_idx + 1));
      end
    end
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(rd_idx));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    release_all();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_col", 32'(col), 32'hF);
    chk("rst_digits", 32'(digits), 32'hFFFF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(digits_valid), 32'h0);
    chk("rst_strobe", 32'(key_strobe), 32'h0);
    chk("rst_code", 32'(key_code), 32'hF);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic entry of four digits.
    pulse_start();
    chk("start_busy", 32'(busy), 32'h1);
    tap(4'h1);
    tap(4'h2);
    tap(4'h3);
    tap(4'h4);
    drain("seq1234");
    chk("done_digits", 32'(digits), 32'h1234);
    chk("done_valid", 32'(digits_valid), 32'h1);
    chk("done_busy", 32'(busy), 32'h0);
    chk("done_col", 32'(col), 32'hF);
    $display("step entry1234 digits=%h valid=%0d", digits, digits_valid);

    // Short press and multi-row column give no strobe.
    pulse_start();
    chk("restart_digits", 32'(digits), 32'hFFFF);
    chk("restart_busy", 32'(busy), 32'h1);
    press(4'h5);
    wait_scans(1);
    release_all();
    wait_scans(3);
    pat[1] = 4'b0011;
    wait_scans(3);
    release_all();
    wait_scans(3);
    drain("glitch");
    chk("glitch_digits", 32'(digits), 32'hFFFF);
    $display("step glitch strobes=%0d", obs_q.size());

    // Clear key in the middle of entry.
    tap(4'h7);
    tap(4'h8);
    tap(4'hA);
    drain("clear");
    chk("clear_digits", 32'(digits), 32'hFFFF);
    tap(4'h9);
    tap(4'h0);
    tap(4'h1);
    tap(4'h2);
    drain("seq9012");
    chk("seq9012_digits", 32'(digits), 32'h9012);
    chk("seq9012_valid", 32'(digits_valid), 32'h1);
    $display("step clear_entry digits=%h", digits);

    // Simultaneous start and abort.
    pulse_start();
    tap(4'h3);
    tap(4'h4);
    drain("partial");
    chk("partial_digits", 32'(digits), 32'hFF34);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_valid", 32'(digits_valid), 32'h0);
    chk("abort_digits", 32'(digits), 32'hFF34);
    chk("abort_col", 32'(col), 32'hF);
    pulse_start();
    chk("after_abort_digits", 32'(digits), 32'hFFFF);
    chk("after_abort_busy", 32'(busy), 32'h1);
    $display("step abort digits=%h busy=%0d", digits, busy);

    // Key held from start yields one strobe; a fresh press yields another.
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    press(4'h0);
    pulse_start();
    wait_scans(6);
    exp_q.push_back(4'h0);
    drain("hold0");
    release_all();
    wait_scans(3);
    tap(4'h0);
    drain("repress0");
    chk("hold_digits", 32'(digits), 32'hFF00);
    $display("step hold0 strobes=%0d digits=%h", obs_q.size(), digits);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
